// File: rtl/ahb_mem_slave_ctrl.sv
// AHB-Lite slave sequencing a single-port synchronous word RAM and an external
// sub-word store-merge datapath (word writes direct, byte/half writes via RMW).
module ahb_mem_slave_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_WORDS = 1024,
  localparam int unsigned RAM_AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [2:0]        st_hsize,
  output logic [31:0]       st_read_data,
  output logic [31:0]       st_wr_data,
  input  logic [31:0]       st_store_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_WORD = 3'd3;
  localparam logic [2:0] S_RMW_RD  = 3'd4;
  localparam logic [2:0] S_RMW_WR  = 3'd5;
  localparam logic [2:0] S_ERR1    = 3'd6;
  localparam logic [2:0] S_ERR2    = 3'd7;

  localparam logic [ADDR_W-1:0] MemLimit = ADDR_W'(MEM_WORDS);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [RAM_AW-1:0] r_addr;
  logic [2:0]        r_size;
  logic [31:0]       r_wdata;
  logic              w_accept;
  logic              w_err;
  logic              w_ram_write;
  logic [ADDR_W-1:0] w_word_idx;
  logic              w_unused_trans;

  assign w_unused_trans = htrans[0];
  assign w_word_idx     = {2'b00, haddr[ADDR_W-1:2]};

  assign w_err = (hsize > 3'b010)
               | ((hsize == 3'b001) & haddr[0])
               | ((hsize == 3'b010) & (haddr[1:0] != 2'b00))
               | (w_word_idx >= MemLimit);

  // Only RD, RMW_RD and ERR1 stall the bus.
  assign hreadyout = ~((r_state == S_RD) | (r_state == S_RMW_RD) | (r_state == S_ERR1));
  assign hresp     = (r_state == S_ERR1) | (r_state == S_ERR2);
  assign w_accept  = hsel & htrans[1] & hready & hreadyout;

  always_comb begin
    w_next_state = S_IDLE;
    if (w_accept) begin
      if (w_err)                 w_next_state = S_ERR1;
      else if (!hwrite)          w_next_state = S_RD;
      else if (hsize == 3'b010)  w_next_state = S_WR_WORD;
      else                       w_next_state = S_RMW_RD;
    end else begin
      unique case (r_state)
        S_RD:     w_next_state = S_RD_DATA;
        S_RMW_RD: w_next_state = S_RMW_WR;
        S_ERR1:   w_next_state = S_ERR2;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr <= haddr[RAM_AW+1:2];
        r_size <= hsize;
      end
      // Write data is only guaranteed during the first data cycle of the RMW.
      if (r_state == S_RMW_RD) r_wdata <= hwdata;
    end
  end

  assign w_ram_write = (r_state == S_WR_WORD) | (r_state == S_RMW_WR);
  assign ram_wdata   = w_ram_write ? st_store_data : '0;

  always_comb begin
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    hrdata       = '0;
    st_hsize     = '0;
    st_read_data = '0;
    st_wr_data   = '0;
    unique case (r_state)
      S_RD, S_RMW_RD: begin
        ram_en   = 1'b1;
        ram_addr = r_addr;
      end
      S_RD_DATA: hrdata = ram_rdata;
      S_WR_WORD: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = r_addr;
        st_hsize   = 3'b010;
        st_wr_data = hwdata;
      end
      S_RMW_WR: begin
        ram_en       = 1'b1;
        ram_we       = 1'b1;
        ram_addr     = r_addr;
        st_hsize     = r_size;
        st_read_data = ram_rdata;
        st_wr_data   = r_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_mem_slave_ctrl.sv
// Directed bench for ahb_mem_slave_ctrl with a behavioural RAM and low-lane
// store-merge model.
module tb_ahb_mem_slave_ctrl;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [2:0]  st_hsize;
  logic [31:0] st_read_data;
  logic [31:0] st_wr_data;
  logic [31:0] st_store_data;

  logic [31:0] mem [1024];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 hclk = ~hclk;

  assign hready = hreadyout;

  assign st_store_data = (st_hsize == 3'b000) ? {st_read_data[31:8], st_wr_data[7:0]} :
                         (st_hsize == 3'b001) ? {st_read_data[31:16], st_wr_data[15:0]} :
                         st_wr_data;

  always @(posedge hclk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  ahb_mem_slave_ctrl #(
    .ADDR_W   (32),
    .MEM_WORDS(1024)
  ) u_dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .hsel         (hsel),
    .htrans       (htrans),
    .hwrite       (hwrite),
    .hsize        (hsize),
    .haddr        (haddr),
    .hwdata       (hwdata),
    .hready       (hready),
    .hreadyout    (hreadyout),
    .hresp        (hresp),
    .hrdata       (hrdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .st_hsize     (st_hsize),
    .st_read_data (st_read_data),
    .st_wr_data   (st_wr_data),
    .st_store_data(st_store_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic mid();
    @(negedge hclk);
  endtask

  task automatic drive(input logic wr, input logic [2:0] size, input logic [31:0] addr);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = size;
    haddr  = addr;
  endtask

  task automatic go_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b000;
    haddr  = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy"}, {31'd0, hreadyout}, 32'd1);
    check({tag, "_resp"}, {31'd0, hresp}, 32'd0);
    check({tag, "_en"}, {31'd0, ram_en}, 32'd0);
    check({tag, "_rdata"}, hrdata, 32'd0);
  endtask

  // Word write from IDLE, completing into IDLE.
  task automatic word_write(input logic [31:0] addr, input logic [31:0] data);
    step(); drive(1'b1, 3'b010, addr);
    step(); go_idle(); hwdata = data;
    step();
  endtask

  initial begin
    hresetn = 1'b0;
    hwdata  = '0;
    go_idle();
    #2;
    check_idle("reset");
    check("reset_we", {31'd0, ram_we}, 32'd0);
    #10 hresetn = 1'b1;

    // Word write then read back-to-back at 0x10.
    step(); drive(1'b1, 3'b010, 32'h10);
    mid();  check("w1_idle_rdy", {31'd0, hreadyout}, 32'd1);
    step(); drive(1'b0, 3'b010, 32'h10); hwdata = 32'hDEADBEEF;
    mid();  check("w1_wr_rdy", {31'd0, hreadyout}, 32'd1);
            check("w1_wr_we", {30'd0, ram_en, ram_we}, 32'd3);
            check("w1_wr_addr", {22'd0, ram_addr}, 32'd4);
            check("w1_wr_data", ram_wdata, 32'hDEADBEEF);
    step(); go_idle();
    mid();  check("r1_rd_rdy", {31'd0, hreadyout}, 32'd0);
            check("r1_rd_en", {30'd0, ram_en, ram_we}, 32'd2);
    step();
    mid();  check("r1_data_rdy", {31'd0, hreadyout}, 32'd1);
            check("r1_data", hrdata, 32'hDEADBEEF);
    step();
    mid();  check_idle("r1_after");

    // Byte RMW over 0x11223344.
    step(); drive(1'b1, 3'b010, 32'h10);
    step(); drive(1'b1, 3'b000, 32'h10); hwdata = 32'h11223344;
    step(); go_idle(); hwdata = 32'hAABBCCDD;
    mid();  check("b_rmwrd_rdy", {31'd0, hreadyout}, 32'd0);
            check("b_rmwrd_en", {30'd0, ram_en, ram_we}, 32'd2);
    step(); hwdata = 32'h0;
    mid();  check("b_rmwwr_rdy", {31'd0, hreadyout}, 32'd1);
            check("b_rmwwr_we", {30'd0, ram_en, ram_we}, 32'd3);
            check("b_st_rd", st_read_data, 32'h11223344);
            check("b_st_wr", st_wr_data, 32'hAABBCCDD);
            check("b_st_size", {29'd0, st_hsize}, 32'd0);
            check("b_ram_wdata", ram_wdata, 32'h112233DD);
    step();
    mid();  check("b_mem", mem[4], 32'h112233DD);

    // Halfword RMW at 0x12, then misaligned halfword at 0x11.
    step(); drive(1'b1, 3'b001, 32'h12);
    step(); go_idle(); hwdata = 32'h0000BEEF;
    mid();  check("h_rmwrd_rdy", {31'd0, hreadyout}, 32'd0);
    step();
    mid();  check("h_st_size", {29'd0, st_hsize}, 32'd1);
    step(); drive(1'b1, 3'b001, 32'h11);
    mid();  check("h_mem", mem[4], 32'h1122BEEF);
    step(); go_idle();
    mid();  check("h_err1", {29'd0, hresp, hreadyout, ram_en}, 32'h4);
    step();
    mid();  check("h_err2", {29'd0, hresp, hreadyout, ram_en}, 32'h6);
    step();
    mid();  check_idle("h_after");

    // Illegal size, out-of-range word, then a valid read at 0x0.
    word_write(32'h0, 32'h0BADF00D);
    drive(1'b0, 3'b011, 32'h0);
    step(); drive(1'b0, 3'b010, 32'h1000);
    mid();  check("e_sz_err1", {29'd0, hresp, hreadyout, ram_en}, 32'h4);
    step();
    mid();  check("e_sz_err2", {29'd0, hresp, hreadyout, ram_en}, 32'h6);
    step(); drive(1'b0, 3'b010, 32'h0);
    mid();  check("e_oob_err1", {29'd0, hresp, hreadyout, ram_en}, 32'h4);
    step();
    mid();  check("e_oob_err2", {29'd0, hresp, hreadyout, ram_en}, 32'h6);
    step(); go_idle();
    mid();  check("e_rd", {29'd0, hresp, hreadyout, ram_en}, 32'h1);
            check("e_rd_addr", {22'd0, ram_addr}, 32'd0);
    step();
    mid();  check("e_rd_data", hrdata, 32'h0BADF00D);
            check("e_rd_resp", {31'd0, hresp}, 32'd0);

    // Pipelined word write, byte RMW, read at 0x20.
    step(); drive(1'b1, 3'b010, 32'h20);
    step(); drive(1'b1, 3'b000, 32'h20); hwdata = 32'hCAFEF00D;
    mid();  check("p_wr_rdy", {31'd0, hreadyout}, 32'd1);
    step(); drive(1'b0, 3'b010, 32'h20); hwdata = 32'h00000077;
    mid();  check("p_rmwrd_rdy", {31'd0, hreadyout}, 32'd0);
    step(); hwdata = 32'h0;
    mid();  check("p_rmwwr_rdy", {31'd0, hreadyout}, 32'd1);
            check("p_rmwwr_data", ram_wdata, 32'hCAFEF077);
    step(); go_idle();
    mid();  check("p_rd", {30'd0, hreadyout, ram_we}, 32'd0);
    step();
    mid();  check("p_rd_data", hrdata, 32'hCAFEF077);
            check("p_rd_rdy", {31'd0, hreadyout}, 32'd1);

    // Reset asserted in RMW_RD abandons the write.
    word_write(32'h30, 32'h12345678);
    drive(1'b1, 3'b000, 32'h30);
    step(); go_idle(); hwdata = 32'h000000FF;
    mid();  check("rst_rmwrd_rdy", {31'd0, hreadyout}, 32'd0);
    #1 hresetn = 1'b0;
    #1 check_idle("rst_async");
       check("rst_async_we", {31'd0, ram_we}, 32'd0);
    step(); step();
    mid();  hresetn = 1'b1;
    step(); step();
    mid();  check("rst_mem", mem[12], 32'h12345678);
            check_idle("rst_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave_ctrl.md
Name: ahb_mem_slave_ctrl

Overview:
- AHB-Lite slave controller that sequences a single-port synchronous word RAM and the external sub-word store-merge datapath.
- Full-word writes complete with zero wait states.
- Byte and halfword writes run a read-modify-write: RAM read, then merge, then write-back, with one wait state.
- Reads take one wait state. Errors are returned for an illegal size, misalignment or an out-of-range address.

Parameters:
- ADDR_W, 32, width of haddr in bits.
- MEM_WORDS, 1024, RAM depth in 32-bit words; ram_addr width is clog2(MEM_WORDS).

Ports:
- hclk  input  1  system clock, rising edge.
- hresetn  input  1  asynchronous active-low reset.
- hsel  input  1  slave select.
- htrans  input  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- hwrite  input  1  1=write, 0=read.
- hsize  input  3  transfer size (000 byte, 001 half, 010 word).
- haddr  input  ADDR_W  byte address.
- hwdata  input  32  write data, valid in data phase.
- hready  input  1  bus ready (hreadyout of the current data-phase slave).
- hreadyout  output  1  slave ready.
- hresp  output  1  0=OKAY, 1=ERROR.
- hrdata  output  32  read data.
- ram_en  output  1  RAM access enable.
- ram_we  output  1  RAM write enable (meaningful only with ram_en).
- ram_addr  output  clog2(MEM_WORDS)  RAM word address.
- ram_wdata  output  32  RAM write data.
- ram_rdata  input  32  RAM read data, valid the cycle after a read enable.
- st_hsize  output  3  size presented to the store-merge datapath.
- st_read_data  output  32  old RAM word presented to the merge.
- st_wr_data  output  32  bus write data presented to the merge.
- st_store_data  input  32  merged word returned from the merge.

Behaviour:
- Accept: address phase is taken when hsel & htrans[1] & hready at a rising edge with hreadyout=1. The block registers haddr, hwrite and hsize. BUSY, IDLE or hsel=0 takes no action and moves to IDLE.
- Word address is haddr[ADDR_W-1:2]. Byte-lane placement belongs to the merge datapath; this block passes hsize only.
- Error check at accept:
  - hsize>010, halfword with haddr[0]=1, word with haddr[1:0]!=0, or word address >= MEM_WORDS → ERR1.
  - No RAM access on an error.
- States:
  - IDLE: hreadyout=1, hresp=0, ram_en=0.
  - RD: ram_en=1, ram_we=0, hreadyout=0 → RD_DATA.
  - RD_DATA: hreadyout=1, hrdata=ram_rdata; may accept the next transfer.
  - WR_WORD: ram_en=1, ram_we=1, st_hsize=010, st_wr_data=hwdata, ram_wdata=st_store_data, hreadyout=1; may accept.
  - RMW_RD: ram_en=1, ram_we=0, hreadyout=0; hwdata is captured into an internal register → RMW_WR.
  - RMW_WR: ram_en=1, ram_we=1, st_read_data=ram_rdata, st_wr_data=captured hwdata, st_hsize=registered hsize, ram_wdata=st_store_data, hreadyout=1; may accept.
  - ERR1: hresp=1, hreadyout=0 → ERR2.
  - ERR2: hresp=1, hreadyout=1; may accept.
- Next state after an accept: read → RD, word write → WR_WORD, byte/half write → RMW_RD, error → ERR1. With no accept, a ready-high state → IDLE.
- Single-port hazard: a RAM write in WR_WORD or RMW_WR never overlaps a read. A transfer accepted in that cycle issues its RAM access in the following cycle, so read-after-write returns the new data.
- hrdata is 0 outside RD_DATA. ram_addr, ram_wdata and the st_* outputs are 0 when ram_en=0.
- Reset (async, any state, mid-transfer included):
  - state=IDLE, hreadyout=1, hresp=0, hrdata=0, ram_en=0, ram_we=0, all registers 0.
  - An in-flight RMW is abandoned and no write is issued.
- No parameter changes timing: read and RMW each take exactly 1 wait state, word write takes 0, error takes 2 cycles.

Test Plan:
- Word write then read, back-to-back at 0x10: data 0xDEADBEEF → write in the data cycle with 0 waits; the read's RD_DATA returns hrdata=0xDEADBEEF after 1 wait state.
- Byte RMW at 0x10 (RAM word 0x11223344), hwdata=0xAABBCCDD, hsize=000 → one hreadyout=0 cycle; RAM is written with st_store_data, 0x112233DD for the standard merge.
- Halfword at 0x12 with hwdata=0x0000BEEF → RAM becomes 0x1122BEEF. A halfword at 0x11 → hresp=1 for 2 cycles (hreadyout 0 then 1) and ram_en stays 0.
- hsize=011, or word address = MEM_WORDS → two-cycle ERROR; a following valid read at 0x0 completes normally.
- Pipelined sequence: write word, byte RMW, read to the same address with no idle cycles → the read returns the merged value and each transfer shows its specified wait-state count.
- Assert hresetn low during RMW_RD → all outputs take their reset values immediately, no RAM write occurs, and the RAM word is unchanged.
